// File: rtl/mux_rr_arbiter_9_pkg.sv
// Shared types and helpers for the round-robin 9:1 mux arbiter.
// Holds the grant state encoding and the select-width derivation.
package mux_rr_arbiter_9_pkg;

  localparam int MAX_N = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Select width for n requesters; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_9_rr_pick.sv
// Combinational wrap-around priority search: first set valid bit
// at or after ptr, wrapping N-1 -> 0.
module rr_pick_first
  import mux_rr_arbiter_9_pkg::*;
#(
  parameter int N  = 9,
  parameter int SW = sel_width(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] idx,
  output logic          found
);

  int k;

  always_comb begin
    // NOTE: every output gets a default before the search loop, otherwise
    // the "no valid bit" path would hold old values and infer latches.
    idx   = '0;
    found = 1'b0;
    k     = 0;
    // Walk offsets from far to near so the nearest valid index wins last.
    for (int i = N - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (valid[k]) begin
        idx   = SW'(k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter_9.sv
// Round-robin arbiter/sequencer for the 9:1 datapath mux: grants one
// requester at a time for bounded bursts into a registered output stage.
module mux_rr_arbiter_9
  import mux_rr_arbiter_9_pkg::*;
#(
  parameter  int N     = 9,
  parameter  int W     = 1,
  parameter  int BURST = 4,
  localparam int SW    = sel_width(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  input  logic [N*W-1:0]  req_data,
  output logic [N-1:0]    req_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  input  logic            out_ready,
  output logic [SW-1:0]   grant_sel,
  output logic            grant_active
);

  localparam int             CW        = $clog2(BURST + 1);
  localparam logic [CW-1:0]  LAST_BEAT = CW'(BURST - 1);
  localparam logic [SW-1:0]  LAST_IDX  = SW'(N - 1);

  state_t        state;
  logic [SW-1:0] ptr;
  logic [CW-1:0] beat_cnt;

  logic [SW-1:0] pick_idx;
  logic          pick_found;
  logic [W-1:0]  mux_data;
  logic          granted_valid;
  logic          out_space;
  logic          accept;
  logic          release_grant;

  rr_pick_first #(
    .N  (N),
    .SW (SW)
  ) u_pick (
    .valid (req_valid),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // The select mux: data and valid of the granted requester.
  always_comb begin
    mux_data      = '0;
    granted_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (grant_sel == SW'(k)) begin
        mux_data      = req_data[k*W +: W];
        granted_valid = req_valid[k];
      end
    end
  end

  assign out_space     = !out_valid || out_ready;
  assign accept        = (state == BUSY) && granted_valid && out_space;
  assign release_grant = (state == BUSY) &&
                         (!granted_valid || (accept && beat_cnt == LAST_BEAT));
  assign grant_active  = (state == BUSY);

  always_comb begin
    req_ready = '0;
    for (int k = 0; k < N; k++) begin
      if ((state == BUSY) && (grant_sel == SW'(k))) req_ready[k] = out_space;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      beat_cnt  <= '0;
      grant_sel <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every branch below sees
      // this cycle's values, independent of statement order.
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= mux_data;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_sel <= pick_idx;
            beat_cnt  <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (release_grant) begin
            state    <= IDLE;
            beat_cnt <= '0;
            ptr      <= (grant_sel == LAST_IDX) ? '0 : grant_sel + 1'b1;
          end else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
